// File: rtl/data_ram_unit.sv
// rtl/data_ram_unit.sv - data SRAM slave with window decode, byte writes and latency-controlled tri-state reads
// Optional feature macro: DATA_RAM_FAULT_EN (adds the sticky mem_fault output and its logic)
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   bus_addr   byte address, compared at full width against the window
//   bus_data   write data in; read data out while a read is being returned, otherwise high-Z
//   mem_cs     access request
//   mem_we     write strobe
//   mem_oe     read strobe
//   mem_ready  one-cycle write acknowledge / read data valid
//   mem_fault  sticky illegal-access flag (DATA_RAM_FAULT_EN only)

module data_ram_unit #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_START_ADDR = 'h40,
  parameter int MEM_STOP_ADDR  = 'hBF,
  parameter int READ_LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  input  logic                  mem_cs,
  input  logic                  mem_we,
  input  logic                  mem_oe,
  output logic                  mem_ready
`ifdef DATA_RAM_FAULT_EN
  ,
  output logic                  mem_fault
`endif
);

  localparam logic [ADDR_WIDTH-1:0] START = ADDR_WIDTH'(MEM_START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STOP  = ADDR_WIDTH'(MEM_STOP_ADDR);
  localparam int                    DEPTH = MEM_STOP_ADDR - MEM_START_ADDR + 1;
  localparam int                    IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]            LAT   = 2'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ACK   = 2'd1,
    RD_WAIT  = 2'd2,
    RD_DRIVE = 2'd3
  } state_t;

  state_t                state;
  logic [1:0]            wait_cnt;
  logic [IDX_W-1:0]      rd_idx;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_window;
  logic                  hit;
  logic                  wr_req;
  logic                  rd_req;
  logic [IDX_W-1:0]      idx;

  // Full-width compare: an address with a non-zero upper byte never aliases into the window.
  assign in_window = (bus_addr >= START) && (bus_addr <= STOP);
  assign hit       = mem_cs && in_window;
  assign wr_req    = hit && mem_we && !mem_oe;
  assign rd_req    = hit && mem_oe && !mem_we;
  assign idx       = IDX_W'(bus_addr - START);

  // Outputs are registered from the state seen at each edge, so a read accepted at
  // edge N first drives at edge N+1+READ_LATENCY and a write acks at edge N+1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 2'd0;
      rd_idx    <= '0;
      drive_en  <= 1'b0;
      mem_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          drive_en  <= 1'b0;
          mem_ready <= 1'b0;
          if (wr_req) begin
            state <= WR_ACK;
          end else if (rd_req) begin
            rd_idx   <= idx;
            wait_cnt <= LAT;
            state    <= (READ_LATENCY == 0) ? RD_DRIVE : RD_WAIT;
          end
        end
        WR_ACK: begin
          drive_en  <= 1'b0;
          mem_ready <= 1'b1;
          state     <= IDLE;
        end
        RD_WAIT: begin
          drive_en  <= 1'b0;
          mem_ready <= 1'b0;
          if (!mem_cs || !mem_oe) begin
            wait_cnt <= 2'd0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
            if (wait_cnt == 2'd1) begin
              state <= RD_DRIVE;
            end
          end
        end
        RD_DRIVE: begin
          // The latched index is used; bus_addr is ignored until the master lets go.
          if (mem_cs && mem_oe) begin
            drive_en  <= 1'b1;
            mem_ready <= 1'b1;
          end else begin
            drive_en  <= 1'b0;
            mem_ready <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          drive_en  <= 1'b0;
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Array is deliberately not reset; contents are undefined after power-up.
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_req) begin
      mem[idx] <= bus_data;
    end
  end

  assign bus_data = drive_en ? mem[rd_idx] : {DATA_WIDTH{1'bz}};

`ifdef DATA_RAM_FAULT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_fault <= 1'b0;
    end else if (mem_cs && (!in_window || (mem_we && mem_oe))) begin
      mem_fault <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_ram_unit.sv
// tb/tb_data_ram_unit.sv - self-checking bench for data_ram_unit (READ_LATENCY 1 and 3 side by side)
module tb_data_ram_unit;

  localparam int RL_A = 1;
  localparam int RL_B = 3;

  logic        clk;
  logic        reset;
  logic [15:0] bus_addr;
  logic        mem_cs;
  logic        mem_we;
  logic        mem_oe;
  logic        tb_drive;
  logic [7:0]  tb_wdata;
  wire  [7:0]  bus_a;
  wire  [7:0]  bus_b;
  logic        ready_a;
  logic        ready_b;
`ifdef DATA_RAM_FAULT_EN
  logic        fault_a;
  logic        fault_b;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  model [0:127];

  assign bus_a = tb_drive ? tb_wdata : 8'hzz;
  assign bus_b = tb_drive ? tb_wdata : 8'hzz;

  data_ram_unit #(
    .DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_START_ADDR('h40), .MEM_STOP_ADDR('hBF), .READ_LATENCY(RL_A)
  ) u_dut_a (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_data(bus_a),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .mem_ready(ready_a)
`ifdef DATA_RAM_FAULT_EN
    , .mem_fault(fault_a)
`endif
  );

  data_ram_unit #(
    .DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_START_ADDR('h40), .MEM_STOP_ADDR('hBF), .READ_LATENCY(RL_B)
  ) u_dut_b (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_data(bus_b),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .mem_ready(ready_b)
`ifdef DATA_RAM_FAULT_EN
    , .mem_fault(fault_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic bit in_win(input logic [15:0] a);
    return (a >= 16'h0040) && (a <= 16'h00BF);
  endfunction

  function automatic logic [6:0] slot(input logic [15:0] a);
    return 7'(a - 16'h0040);
  endfunction

  // Released bus reads as z in a 4-state simulator and 0 in a 2-state one.
  function automatic bit undriven(input logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    mem_cs   = 1'b0;
    mem_we   = 1'b0;
    mem_oe   = 1'b0;
    tb_drive = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input bit chk);
    bit win;
    bit e;
    win      = in_win(addr);
    bus_addr = addr;
    tb_wdata = data;
    tb_drive = 1'b1;
    mem_cs   = 1'b1;
    mem_we   = 1'b1;
    mem_oe   = 1'b0;
    tick();
    bus_idle();
    if (win) model[slot(addr)] = data;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      e = win && (k == 1);
      if (chk) begin
        n_checks++;
        if ({ready_a, ready_b} !== {e, e}) begin
          n_fail++;
          $display("FAIL wr_ready addr=%h k=%0d got=%b%b want=%b%b", addr, k, ready_a, ready_b, e, e);
        end
      end
    end
  endtask

  task automatic do_read(input logic [15:0] addr, input int hold, input bit move_addr);
    logic [7:0]  want;
    logic [15:0] alt;
    bit          win;
    bit          ea;
    bit          eb;
    win  = in_win(addr);
    want = win ? model[slot(addr)] : 8'h00;
    alt  = addr;
    if (move_addr && win) begin
      for (int t = 0; t < 8; t++) begin
        alt = 16'h0040 + 16'($urandom_range(0, 127));
        if (model[slot(alt)] != want) break;
      end
    end
    bus_addr = addr;
    tb_drive = 1'b0;
    mem_we   = 1'b0;
    mem_cs   = 1'b1;
    mem_oe   = 1'b1;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (k == 0) bus_addr = alt;
      ea = win && (k >= RL_A + 1);
      eb = win && (k >= RL_B + 1);
      n_checks++;
      if ({ready_a, ready_b} !== {ea, eb}) begin
        n_fail++;
        $display("FAIL rd_ready addr=%h k=%0d got=%b%b want=%b%b", addr, k, ready_a, ready_b, ea, eb);
      end
      n_checks++;
      if (ea ? (bus_a !== want) : !undriven(bus_a)) begin
        n_fail++;
        $display("FAIL rd_data_a addr=%h k=%0d got=%h want=%h driven=%b", addr, k, bus_a, want, ea);
      end
      n_checks++;
      if (eb ? (bus_b !== want) : !undriven(bus_b)) begin
        n_fail++;
        $display("FAIL rd_data_b addr=%h k=%0d got=%h want=%h driven=%b", addr, k, bus_b, want, eb);
      end
    end
    bus_idle();
    tick();
    n_checks++;
    if ({ready_a, ready_b} !== 2'b00 || !undriven(bus_a) || !undriven(bus_b)) begin
      n_fail++;
      $display("FAIL rd_release addr=%h got ready=%b%b bus=%h/%h want ready=00 bus released", addr, ready_a, ready_b, bus_a, bus_b);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus_addr = 16'h0000;
    tb_wdata = 8'h00;
    bus_idle();
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({ready_a, ready_b} !== 2'b00 || !undriven(bus_a) || !undriven(bus_b)) begin
      n_fail++;
      $display("FAIL reset_async got ready=%b%b bus=%h/%h want ready=00 bus released", ready_a, ready_b, bus_a, bus_b);
    end
`ifdef DATA_RAM_FAULT_EN
    n_checks++;
    if ({fault_a, fault_b} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_fault got=%b%b want=00", fault_a, fault_b);
    end
`endif
    tick();
    tick();
    n_checks++;
    if ({ready_a, ready_b} !== 2'b00 || !undriven(bus_a) || !undriven(bus_b)) begin
      n_fail++;
      $display("FAIL reset_held got ready=%b%b bus=%h/%h want ready=00 bus released", ready_a, ready_b, bus_a, bus_b);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic prefill();
    for (int a = 'h40; a <= 'hBF; a++) begin
      do_write(16'(a), 8'($urandom_range(1, 255)), 1'b0);
    end
  endtask

  task automatic test_basic();
    do_write(16'h0040, 8'hA5, 1'b1);
    do_read(16'h0040, 6, 1'b0);
  endtask

  task automatic test_push_pop();
    do_write(16'h00BF, 8'h3C, 1'b1);
    do_read(16'h00BF, 6, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [8];
    logic [7:0]  d;
    for (int i = 0; i < 8; i++) addrs[i] = 16'h0040 + 16'($urandom_range(0, 127));
    for (int i = 0; i < 8; i++) begin
      d        = 8'($urandom_range(1, 255));
      bus_addr = addrs[i];
      tb_wdata = d;
      tb_drive = 1'b1;
      mem_cs   = 1'b1;
      mem_we   = 1'b1;
      mem_oe   = 1'b0;
      tick();
      model[slot(addrs[i])] = d;
      bus_idle();
      n_checks++;
      if ({ready_a, ready_b} !== 2'b00) begin
        n_fail++;
        $display("FAIL b2b_ready_lo i=%0d got=%b%b want=00", i, ready_a, ready_b);
      end
      tick();
      n_checks++;
      if ({ready_a, ready_b} !== 2'b11) begin
        n_fail++;
        $display("FAIL b2b_ready_hi i=%0d got=%b%b want=11", i, ready_a, ready_b);
      end
    end
    for (int i = 0; i < 8; i++) do_read(addrs[i], 6, 1'b0);
  endtask

  task automatic test_random_reads();
    for (int i = 0; i < 10; i++) begin
      do_read(16'h0040 + 16'($urandom_range(0, 127)), 6, 1'b1);
    end
  endtask

  task automatic test_abort();
    logic [15:0] a;
    a        = 16'h0040 + 16'($urandom_range(0, 127));
    bus_addr = a;
    mem_cs   = 1'b1;
    mem_oe   = 1'b1;
    tick();
    mem_cs = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({ready_a, ready_b} !== 2'b00 || !undriven(bus_a) || !undriven(bus_b)) begin
        n_fail++;
        $display("FAIL abort k=%0d got ready=%b%b bus=%h/%h want ready=00 bus released", k, ready_a, ready_b, bus_a, bus_b);
      end
    end
    bus_idle();
    do_read(a, 6, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [15:0] a;
    a        = 16'h0040 + 16'($urandom_range(0, 127));
    bus_addr = a;
    mem_cs   = 1'b1;
    mem_oe   = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({ready_a, ready_b} !== 2'b00 || !undriven(bus_a) || !undriven(bus_b)) begin
      n_fail++;
      $display("FAIL reset_mid_async got ready=%b%b bus=%h/%h want ready=00 bus released", ready_a, ready_b, bus_a, bus_b);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({ready_a, ready_b} !== 2'b00 || !undriven(bus_a) || !undriven(bus_b)) begin
        n_fail++;
        $display("FAIL reset_mid_held k=%0d got ready=%b%b bus=%h/%h want ready=00 bus released", k, ready_a, ready_b, bus_a, bus_b);
      end
    end
`ifdef DATA_RAM_FAULT_EN
    n_checks++;
    if ({fault_a, fault_b} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_fault got=%b%b want=00", fault_a, fault_b);
    end
`endif
    bus_idle();
    reset = 1'b1;
    tick();
    do_read(a, 6, 1'b1);
  endtask

  task automatic test_boundary();
    logic [7:0] d;
`ifdef DATA_RAM_FAULT_EN
    n_checks++;
    if ({fault_a, fault_b} !== 2'b00) begin
      n_fail++;
      $display("FAIL bound_fault_pre got=%b%b want=00", fault_a, fault_b);
    end
`endif
    d = 8'($urandom_range(1, 255));
    do_write(16'h00BF, d, 1'b1);
    do_write(16'h00C0, ~d | 8'h01, 1'b1);
    do_write(16'h0140, ~d | 8'h01, 1'b1);
    do_read(16'h00BF, 6, 1'b0);
    do_read(16'h00C0, 6, 1'b0);
    do_read(16'h0140, 6, 1'b0);
    do_read(16'h003F, 6, 1'b0);
    do_read(16'h0040, 6, 1'b0);
`ifdef DATA_RAM_FAULT_EN
    n_checks++;
    if ({fault_a, fault_b} !== 2'b11) begin
      n_fail++;
      $display("FAIL bound_fault_post got=%b%b want=11", fault_a, fault_b);
    end
`endif
  endtask

  task automatic test_illegal();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bus_addr = 16'h0050;
    tb_drive = 1'b0;
    mem_cs   = 1'b1;
    mem_we   = 1'b1;
    mem_oe   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({ready_a, ready_b} !== 2'b00 || !undriven(bus_a) || !undriven(bus_b)) begin
        n_fail++;
        $display("FAIL illegal k=%0d got ready=%b%b bus=%h/%h want ready=00 bus released", k, ready_a, ready_b, bus_a, bus_b);
      end
    end
    bus_idle();
    tick();
`ifdef DATA_RAM_FAULT_EN
    n_checks++;
    if ({fault_a, fault_b} !== 2'b11) begin
      n_fail++;
      $display("FAIL illegal_fault got=%b%b want=11", fault_a, fault_b);
    end
`endif
    do_read(16'h0050, 6, 1'b0);
`ifdef DATA_RAM_FAULT_EN
    n_checks++;
    if ({fault_a, fault_b} !== 2'b11) begin
      n_fail++;
      $display("FAIL illegal_fault_sticky got=%b%b want=11", fault_a, fault_b);
    end
`endif
  endtask

  initial begin
    test_reset();
    prefill();
    test_basic();
    test_push_pop();
    test_back_to_back();
    test_random_reads();
    test_abort();
    test_reset_mid();
    test_boundary();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
